// File: rtl/clint.sv
// Core-local interruptor: msip, a free-running 64-bit mtime with prescaler and a
// 64-bit mtimecmp, exposed over a single-beat strobe/ack bus.

module clint_byte_merge (
  input  logic [7:0] old_i,
  input  logic [7:0] new_i,
  input  logic       en_i,
  output logic [7:0] merged_o
);
  assign merged_o = en_i ? new_i : old_i;
endmodule

module clint #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0200_0000,
  parameter int unsigned PRESCALE     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        timer_interrupt,
  output logic        software_interrupt
);
  localparam int unsigned NUM_LANES = 4;
  localparam int          PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);

  localparam logic [15:0] OFF_MSIP    = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
  localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
  localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;

  typedef enum logic {IDLE, ACK} state_t;

  typedef struct packed {
    logic        we;
    logic [15:0] off;
    logic [31:0] data;
    logic [3:0]  sel;
  } req_t;

  state_t        state_q, state_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [31:0]   data_q, data_d;
  logic          ti_q, ti_d;

  req_t req;
  logic hit, accept, wr_en, tick;
  logic [NUM_LANES-1:0][7:0] rd_word, wr_data, wr_word;
  logic [1:0] adr_unused;

  assign adr_unused = adr_i[1:0];
  assign req = '{we: we_i, off: {adr_i[15:2], 2'b00}, data: data_i, sel: sel_i};
  assign wr_data = req.data;

  always_comb begin
    rd_word = '0;
    case (req.off)
      OFF_MSIP:    rd_word = {31'b0, msip_q};
      OFF_CMP_LO:  rd_word = mtimecmp_q[31:0];
      OFF_CMP_HI:  rd_word = mtimecmp_q[63:32];
      OFF_TIME_LO: rd_word = mtime_q[31:0];
      OFF_TIME_HI: rd_word = mtime_q[63:32];
      default:     rd_word = '0;
    endcase
  end

  // Each lane keeps the current register byte unless its enable is set.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    clint_byte_merge u_merge (
      .old_i    (rd_word[l]),
      .new_i    (wr_data[l]),
      .en_i     (req.sel[l]),
      .merged_o (wr_word[l])
    );
  end

  always_comb begin
    hit    = stb_i && (adr_i[31:16] == BASE_ADDRESS[31:16]);
    accept = (state_q == IDLE) && hit;
    wr_en  = accept && req.we && (|req.sel);
    tick   = (pcnt_q == PCNT_MAX);

    state_d    = IDLE;
    pcnt_d     = tick ? '0 : pcnt_q + PW'(1);
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    data_d     = data_q;
    ti_d       = (mtime_q >= mtimecmp_q);

    case (state_q)
      IDLE:    state_d = accept ? ACK : IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept && !req.we) data_d = rd_word;

    // An mtime write replaces the whole 64-bit value, so a coincident tick is lost.
    if (wr_en) begin
      case (req.off)
        OFF_MSIP:    msip_d     = wr_word[0][0];
        OFF_CMP_LO:  mtimecmp_d = {mtimecmp_q[63:32], wr_word};
        OFF_CMP_HI:  mtimecmp_d = {wr_word, mtimecmp_q[31:0]};
        OFF_TIME_LO: mtime_d    = {mtime_q[63:32], wr_word};
        OFF_TIME_HI: mtime_d    = {wr_word, mtime_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      pcnt_q     <= '0;
      data_q     <= '0;
      ti_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      pcnt_q     <= pcnt_d;
      data_q     <= data_d;
      ti_q       <= ti_d;
    end
  end

  assign data_o             = data_q;
  assign ack_o              = (state_q == ACK);
  assign timer_interrupt    = ti_q;
  assign software_interrupt = msip_q;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: two instances (PRESCALE 1 and 4) on a shared bus, checked every
// cycle against a transaction-level model plus directed vectors and sequences.

module tb_clint;
  logic        clk, rst, stb, we;
  logic [31:0] adr, wdata;
  logic [3:0]  sel;
  logic [31:0] rd1, rd4;
  logic        ack1, ack4, ti1, ti4, si1, si4;

  int checks = 0;
  int errors = 0;
  logic prev_ack = 1'b0;

  clint #(.BASE_ADDRESS(32'h0200_0000), .PRESCALE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .stb_i(stb), .we_i(we), .adr_i(adr), .data_i(wdata),
    .sel_i(sel), .data_o(rd1), .ack_o(ack1), .timer_interrupt(ti1),
    .software_interrupt(si1));

  clint #(.BASE_ADDRESS(32'h0200_0000), .PRESCALE(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .stb_i(stb), .we_i(we), .adr_i(adr), .data_i(wdata),
    .sel_i(sel), .data_o(rd4), .ack_o(ack4), .timer_interrupt(ti4),
    .software_interrupt(si4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic        msip;
    int unsigned pcnt;
    logic        busy;
    logic [31:0] data;
    logic        ti;
  } mst_t;

  mst_t m1, m4;

  function automatic mst_t mreset();
    mst_t r;
    r.mtime = 64'd0; r.cmp = '1; r.msip = 1'b0; r.pcnt = 0;
    r.busy = 1'b0; r.data = 32'd0; r.ti = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] mread(mst_t s, logic [15:0] off);
    case (off)
      16'h0000: return {31'b0, s.msip};
      16'h4000: return s.cmp[31:0];
      16'h4004: return s.cmp[63:32];
      16'hBFF8: return s.mtime[31:0];
      16'hBFFC: return s.mtime[63:32];
      default:  return 32'd0;
    endcase
  endfunction

  function automatic mst_t mstep(mst_t s, int unsigned p, logic stb_v, logic we_v,
                                 logic [31:0] a, logic [31:0] d, logic [3:0] sl);
    mst_t n;
    logic [31:0] cur, mask, w;
    logic [15:0] off;
    n = s;
    n.ti = (s.mtime >= s.cmp);
    if (s.pcnt == p - 1) n.mtime = s.mtime + 64'd1;
    n.pcnt = (s.pcnt + 1) % p;
    n.busy = 1'b0;
    if (stb_v && !s.busy && a[31:16] == 16'h0200) begin
      n.busy = 1'b1;
      off = a[15:0] & 16'hFFFC;
      cur = mread(s, off);
      if (!we_v) n.data = cur;
      else if (sl != 4'b0) begin
        mask = 32'd0;
        for (int b = 0; b < 4; b++) if (sl[b]) mask[b*8 +: 8] = 8'hFF;
        w = (cur & ~mask) | (d & mask);
        case (off)
          16'h0000: n.msip = w[0];
          16'h4000: n.cmp[31:0] = w;
          16'h4004: n.cmp[63:32] = w;
          16'hBFF8: n.mtime = {s.mtime[63:32], w};
          16'hBFFC: n.mtime = {w, s.mtime[31:0]};
          default: ;
        endcase
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= mreset();
      m4 <= mreset();
    end else begin
      m1 <= mstep(m1, 1, stb, we, adr, wdata, sel);
      m4 <= mstep(m4, 4, stb, we, adr, wdata, sel);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("ack1", ack1, m1.busy);     chk("ack4", ack4, m4.busy);
    chk("data1", rd1, m1.data);     chk("data4", rd4, m4.data);
    chk("ti1", ti1, m1.ti);         chk("ti4", ti4, m4.ti);
    chk("si1", si1, m1.msip);       chk("si4", si4, m4.msip);
    chk("ack_pulse", prev_ack && ack1, 1'b0);
    prev_ack = ack1;
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r1, output logic [31:0] r4,
                     output logic acked);
    stb = 1'b1; we = w; adr = a; wdata = d; sel = s;
    acked = 1'b0;
    r1 = 32'd0; r4 = 32'd0;
    for (int i = 0; i < 6 && !acked; i++) begin
      tick();
      if (ack1) begin
        acked = 1'b1; r1 = rd1; r4 = rd4;
      end
    end
    stb = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        exp_ack;
    logic [31:0] exp_rd;
    logic        exp_si;
  } vec_t;

  localparam int NV = 15;
  vec_t vt[NV];

  initial begin
    logic [31:0] r1, r4, a;
    logic acked, w;

    vt[0]  = '{1'b0, 32'h0200_4004, 32'h0,         4'hF, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vt[1]  = '{1'b0, 32'h0200_4000, 32'h0,         4'hF, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vt[2]  = '{1'b1, 32'h0200_0000, 32'h1,         4'hF, 1'b1, 32'h0,         1'b1};
    vt[3]  = '{1'b0, 32'h0200_0000, 32'h0,         4'hF, 1'b1, 32'h1,         1'b1};
    vt[4]  = '{1'b0, 32'h0200_1234, 32'h0,         4'hF, 1'b1, 32'h0,         1'b1};
    vt[5]  = '{1'b1, 32'h0200_0000, 32'h0,         4'hF, 1'b1, 32'h0,         1'b0};
    vt[6]  = '{1'b0, 32'h0200_0000, 32'h0,         4'hF, 1'b1, 32'h0,         1'b0};
    vt[7]  = '{1'b1, 32'h0200_4000, 32'hAABB_CCDD, 4'h5, 1'b1, 32'h0,         1'b0};
    vt[8]  = '{1'b0, 32'h0200_4000, 32'h0,         4'hF, 1'b1, 32'hFFBB_FFDD, 1'b0};
    vt[9]  = '{1'b1, 32'h0200_4000, 32'h1234_5678, 4'h0, 1'b1, 32'h0,         1'b0};
    vt[10] = '{1'b0, 32'h0200_4000, 32'h0,         4'hF, 1'b1, 32'hFFBB_FFDD, 1'b0};
    vt[11] = '{1'b1, 32'h1000_0000, 32'h1,         4'hF, 1'b0, 32'h0,         1'b0};
    vt[12] = '{1'b1, 32'h0200_4004, 32'h0,         4'h3, 1'b1, 32'h0,         1'b0};
    vt[13] = '{1'b0, 32'h0200_4004, 32'h0,         4'hF, 1'b1, 32'hFFFF_0000, 1'b0};
    vt[14] = '{1'b1, 32'h0200_1234, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0,         1'b0};

    rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; wdata = '0; sel = '0;
    repeat (3) tick();
    chk("rst_ack", ack1, 1'b0); chk("rst_data", rd1, 32'd0);
    chk("rst_ti", ti1, 1'b0);   chk("rst_si", si4, 1'b0);
    rst = 1'b0;

    // 40 edges after release: 40 increments at PRESCALE 1, 10 at PRESCALE 4.
    repeat (40) tick();
    bus(1'b0, 32'h0200_BFF8, 32'h0, 4'hF, r1, r4, acked);
    chk("presc_ack", acked, 1'b1);
    chk("mtime_p1", r1, 32'd40);
    chk("mtime_p4", r4, 32'd10);
    tick();

    for (int i = 0; i < NV; i++) begin
      bus(vt[i].we, vt[i].adr, vt[i].data, vt[i].sel, r1, r4, acked);
      chk($sformatf("vec%0d_ack", i), acked, vt[i].exp_ack);
      if (!vt[i].we && vt[i].exp_ack) begin
        chk($sformatf("vec%0d_rd1", i), r1, vt[i].exp_rd);
        chk($sformatf("vec%0d_rd4", i), r4, vt[i].exp_rd);
      end
      chk($sformatf("vec%0d_si", i), si1, vt[i].exp_si);
      tick();
    end

    stb = 1'b1; we = 1'b0; adr = 32'h0200_BFF8; sel = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("b2b_ack%0d", i), ack1, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    stb = 1'b0;
    tick();

    bus(1'b1, 32'h0200_4000, 32'h0, 4'hF, r1, r4, acked);
    bus(1'b1, 32'h0200_4004, 32'h1, 4'hF, r1, r4, acked);
    bus(1'b1, 32'h0200_BFFC, 32'h0, 4'hF, r1, r4, acked);
    bus(1'b1, 32'h0200_BFF8, 32'hFFFF_FFFE, 4'hF, r1, r4, acked);
    chk("tmr_wr_ack", acked, 1'b1);
    tick(); tick();
    chk("tmr_not_yet", ti1, 1'b0);
    tick();
    chk("tmr_rise", ti1, 1'b1);
    tick();
    bus(1'b1, 32'h0200_4004, 32'hFFFF_FFFF, 4'hF, r1, r4, acked);
    chk("tmr_still", ti1, 1'b1);
    tick();
    chk("tmr_drop", ti1, 1'b0);
    tick();

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 7))
        0: a = 32'h0200_0000;
        1: a = 32'h0200_4000;
        2: a = 32'h0200_4004;
        3: a = 32'h0200_BFF8;
        4: a = 32'h0200_BFFC;
        5: a = 32'h0200_0000 | ($urandom & 32'h0000_FFFF);
        6: a = 32'h0201_4000;
        default: a = 32'h1000_0000 | ($urandom & 32'h0000_FFFF);
      endcase
      w = $urandom_range(0, 1) == 1;
      bus(w, a, $urandom, 4'($urandom), r1, r4, acked);
      chk("rnd_ack", acked, (a[31:16] == 16'h0200) ? 1'b1 : 1'b0);
      repeat ($urandom_range(1, 3)) tick();
    end

    stb = 1'b1; we = 1'b1; adr = 32'h0200_0000; wdata = 32'h1; sel = 4'hF;
    tick();
    chk("rstmid_ack", ack1, 1'b1);
    chk("rstmid_si", si1, 1'b1);
    stb = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_ack1_drop", ack1, 1'b0);
    chk("rstmid_ack4_drop", ack4, 1'b0);
    chk("rstmid_si_clr", si1, 1'b0);
    chk("rstmid_data_clr", rd4, 32'd0);
    prev_ack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    bus(1'b0, 32'h0200_4004, 32'h0, 4'hF, r1, r4, acked);
    chk("post_rst_cmp_hi", r1, 32'hFFFF_FFFF);
    tick();
    bus(1'b0, 32'h0200_BFFC, 32'h0, 4'hF, r1, r4, acked);
    chk("post_rst_time_hi", r4, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
